inst_cache: RTL and testbench

- Direct-mapped instruction cache between the core's instruction-fetch port and slower external instruction memory.
- Upstream side: the core drives ce_i/addr_i and consumes data_o in the same cycle, like a combinational ROM.
- On a miss, raises stallreq_o (a new stall source into ctrl) and refills a 4-word line over a req/ack handshake.

---
 rtl/inst_cache.sv | 174 +++++++++++++++++
 tb/tb_inst_cache.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
// -----------------------------------------------------------------------------
// inst_cache -- direct-mapped instruction cache, 2^INDEX_W lines of 4 words.
//
// The core sees a combinational ROM: data_o and stallreq_o are derived in the
// same cycle from ce_i/addr_i. A miss stalls the core and refills the whole
// line from external memory one word at a time, then commits tag/valid.
//
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   ce_i, addr_i     fetch enable and byte address (bits [1:0] ignored)
//   data_o           fetched instruction word (0 when no hit)
//   stallreq_o       stall request to the pipeline controller
//   flush_i          one-cycle pulse, invalidates every line
//   mem_req_o        external word read request
//   mem_addr_o       external word address (4-byte aligned)
//   mem_ack_i        external read complete, mem_data_i valid this cycle
//   mem_data_i       external read data
//   dbg_state        current FSM state (IDLE=0, REFILL=1, COMMIT=2)
//   hit_cnt_o        saturating hit counter      (ICACHE_STATS_EN only)
//   miss_cnt_o       saturating refill counter   (ICACHE_STATS_EN only)
//
// Memory handshake: mem_req_o/mem_addr_o are held stable until a cycle in
// which mem_ack_i is high; that cycle transfers mem_data_i. After an ack the
// request stays high with the next word address. An ack while mem_req_o is
// low carries no data and is ignored.
//
// Optional build macro: ICACHE_STATS_EN adds the hit/miss counters.
// -----------------------------------------------------------------------------
module inst_cache #(
    parameter int INDEX_W = 4,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [31:0]       data_o,
    output logic              stallreq_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_data_i,
    output logic [1:0]        dbg_state
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W - 4;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t             state;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES][4];

    logic [TAG_W-1:0]   lat_tag;
    logic [INDEX_W-1:0] lat_index;
    logic [1:0]         cnt;
    logic               flush_seen;   // a flush arrived during this refill

    logic [1:0]         offset;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic [1:0]         next_cnt;
    logic               addr_unused;

    assign offset      = addr_i[3:2];
    assign index       = addr_i[INDEX_W+3:4];
    assign tag         = addr_i[ADDR_W-1:INDEX_W+4];
    assign addr_unused = ^addr_i[1:0];
    assign next_cnt    = cnt + 2'd1;

    // Lookups only hit in IDLE so a line is never read while it is refilled.
    assign hit        = ce_i & valid[index] & (tag_mem[index] == tag) & (state == IDLE);
    assign data_o     = hit ? data_mem[index][offset] : 32'd0;
    assign stallreq_o = ce_i & ~hit;
    assign dbg_state  = state;

    // Line storage: data and tag are not reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (state == REFILL && mem_ack_i) begin
            data_mem[lat_index][cnt] <= mem_data_i;
        end
        if (state == COMMIT) begin
            tag_mem[lat_index] <= lat_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            valid      <= '0;
            lat_tag    <= '0;
            lat_index  <= '0;
            cnt        <= 2'd0;
            flush_seen <= 1'b0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_i) begin
                        valid <= '0;
                    end
                    if (ce_i && !hit) begin
                        state      <= REFILL;
                        lat_tag    <= tag;
                        lat_index  <= index;
                        cnt        <= 2'd0;
                        flush_seen <= 1'b0;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= {tag, index, 4'b0000};
                    end
                end
                REFILL: begin
                    // The burst always completes; a flush only stops the commit.
                    if (flush_i) begin
                        valid      <= '0;
                        flush_seen <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        cnt <= next_cnt;
                        if (cnt == 2'd3) begin
                            state     <= COMMIT;
                            mem_req_o <= 1'b0;
                        end else begin
                            mem_addr_o <= {lat_tag, lat_index, next_cnt, 2'b00};
                        end
                    end
                end
                COMMIT: begin
                    if (flush_i) begin
                        valid <= '0;
                    end else if (!flush_seen) begin
                        valid[lat_index] <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_o  <= 32'd0;
            miss_cnt_o <= 32'd0;
        end else begin
            if (hit && hit_cnt_o != 32'hFFFF_FFFF) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end
            if (state == IDLE && ce_i && !hit && miss_cnt_o != 32'hFFFF_FFFF) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// -----------------------------------------------------------------------------
// tb_inst_cache -- self-checking bench for inst_cache.
// An external memory responder returns a fixed function of the word address.
// A line-level reference model (valid/tag per index plus the current refill
// transaction) predicts data_o, stallreq_o and the request stream.
// -----------------------------------------------------------------------------
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic [31:0] addr_i;
    logic [31:0] data_o;
    logic        stallreq_o;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic [1:0]  dbg_state;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inst_cache #(.INDEX_W(4), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .addr_i     (addr_i),
        .data_o     (data_o),
        .stallreq_o (stallreq_o),
        .flush_i    (flush_i),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_data_i (mem_data_i),
        .dbg_state  (dbg_state)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
`endif
    );

    // ---------------- external memory ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a < 32'h10) w = 32'h1111_1111 * ({30'd0, a[3:2]} + 32'd1);
        else            w = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        return w;
    endfunction

    bit rand_ack = 1'b0;
    bit last_req = 1'b0;
    initial begin
        mem_ack_i  = 1'b0;
        mem_data_i = 32'd0;
    end

    // Ack arrives one cycle after req is first seen, then every cycle while
    // req stays high; random mode inserts waits and stray acks while idle.
    always @(posedge clk) begin
        #1;
        if (rand_ack)
            mem_ack_i = mem_req_o ? (last_req && ($urandom_range(0, 2) != 0))
                                  : ($urandom_range(0, 3) == 0);
        else
            mem_ack_i = mem_req_o && last_req;
        mem_data_i = mem_word(mem_addr_o);
        last_req   = mem_req_o;
    end

    // ---------------- reference model ----------------
    bit          m_valid [16];
    logic [23:0] m_tag   [16];
    int          m_phase;       // 0 lookup, 1 refilling, 2 committing
    logic [31:0] m_base;
    int          m_acks;
    bit          m_supp;
    bit          have_prev;

    bit          exp_hit, exp_stall, exp_req;
    logic [31:0] exp_data, exp_addr;

    function automatic bit model_hit(input logic ce, input logic [31:0] a);
        return ce && m_phase == 0 && m_valid[a[7:4]] && m_tag[a[7:4]] == a[31:8];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_phase   = 0;
        m_acks    = 0;
        m_base    = 32'd0;
        m_supp    = 1'b0;
        have_prev = 1'b0;
    endtask

    task automatic model_expect();
        exp_hit   = model_hit(ce_i, addr_i);
        exp_stall = ce_i && !exp_hit;
        exp_data  = exp_hit ? mem_word({addr_i[31:2], 2'b00}) : 32'd0;
        exp_req   = (m_phase == 1);
        exp_addr  = m_base + 32'(4 * m_acks);
    endtask

    // Applies the previous cycle's inputs to the model (inputs are still stable).
    task automatic model_update();
        bit h;
        if (!have_prev) return;
        h = model_hit(ce_i, addr_i);
        if (flush_i) for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        case (m_phase)
            0: if (ce_i && !h) begin
                m_phase = 1;
                m_base  = {addr_i[31:4], 4'b0000};
                m_acks  = 0;
                m_supp  = 1'b0;
            end
            1: begin
                if (flush_i) m_supp = 1'b1;
                if (mem_ack_i) begin
                    m_acks++;
                    if (m_acks == 4) m_phase = 2;
                end
            end
            default: begin
                if (!m_supp && !flush_i) begin
                    m_valid[m_base[7:4]] = 1'b1;
                    m_tag[m_base[7:4]]   = m_base[31:8];
                end
                m_phase = 0;
            end
        endcase
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic ce, input logic [31:0] a, input logic fl);
        model_update();
        @(posedge clk);
        #1;
        ce_i    = ce;
        addr_i  = a;
        flush_i = fl;
        have_prev = 1'b1;
        @(negedge clk);
        model_expect();
    endtask

    logic [31:0] ack_log[$];

    // Fetches 'a' until the stall clears; logs acked addresses.
    task automatic run_fill(input logic [31:0] a, output bit first_stall, output bit timed_out);
        ack_log.delete();
        timed_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, a, 1'b0);
            if (i == 0) first_stall = stallreq_o;
            if (mem_req_o && mem_ack_i) ack_log.push_back(mem_addr_o);
            if (!stallreq_o) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; ce_i = 1'b0; addr_i = 32'd0; flush_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (data_o !== 32'd0)     begin n_err++; $display("FAIL reset_data got %h exp 0", data_o); end
        n_cmp++; if (stallreq_o !== 1'b0)  begin n_err++; $display("FAIL reset_stall got %b exp 0", stallreq_o); end
        n_cmp++; if (mem_req_o !== 1'b0)   begin n_err++; $display("FAIL reset_req got %b exp 0", mem_req_o); end
        n_cmp++; if (mem_addr_o !== 32'd0) begin n_err++; $display("FAIL reset_addr got %h exp 0", mem_addr_o); end
        n_cmp++; if (dbg_state !== 2'd0)   begin n_err++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
`ifdef ICACHE_STATS_EN
        n_cmp++; if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
            n_err++; $display("FAIL reset_stats got %0d/%0d exp 0/0", hit_cnt_o, miss_cnt_o); end
`endif
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_cold_miss();
        logic [31:0] exp_q[$];
        logic [31:0] e;
        int          stall_cycles = 0;
        bit          done = 1'b0;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 20 && !done; i++) begin
            cycle(1'b1, 32'h0, 1'b0);
            if (mem_req_o && mem_ack_i) begin
                e = (exp_q.size() > 0) ? exp_q[0] : 32'hxxxx_xxxx;
                n_cmp++;
                if (exp_q.size() == 0 || mem_addr_o !== e) begin
                    n_err++; $display("FAIL cold_req_addr got %h exp %h", mem_addr_o, e);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (stallreq_o) stall_cycles++;
            else done = 1'b1;
        end
        n_cmp++; if (!done || stall_cycles != 7) begin
            n_err++; $display("FAIL cold_stall_cycles got %0d exp 7", stall_cycles); end
        n_cmp++; if (exp_q.size() != 0) begin
            n_err++; $display("FAIL cold_words_missing got %0d exp 0", exp_q.size()); end
        n_cmp++; if (data_o !== 32'h1111_1111) begin
            n_err++; $display("FAIL cold_data got %h exp 11111111", data_o); end
    endtask

    task automatic test_sequential_hits();
        for (int k = 1; k < 4; k++) begin
            cycle(1'b1, 32'(4 * k), 1'b0);
            n_cmp++; if (data_o !== 32'h1111_1111 * 32'(k + 1)) begin
                n_err++; $display("FAIL seq_data[%0d] got %h exp %h", k, data_o, 32'h1111_1111 * 32'(k + 1)); end
            n_cmp++; if (stallreq_o !== 1'b0 || mem_req_o !== 1'b0) begin
                n_err++; $display("FAIL seq_stall_req[%0d] got %b%b exp 00", k, stallreq_o, mem_req_o); end
        end
    endtask

    task automatic test_conflict();
        bit fs, to;
        run_fill(32'h100, fs, to);
        n_cmp++; if (to || !fs) begin
            n_err++; $display("FAIL conflict_miss1 got stall0=%b timeout=%b exp 1/0", fs, to); end
        n_cmp++; if (ack_log.size() != 4) begin
            n_err++; $display("FAIL conflict_words got %0d exp 4", ack_log.size()); end
        for (int i = 0; i < ack_log.size() && i < 4; i++) begin
            n_cmp++; if (ack_log[i] !== 32'h100 + 32'(4 * i)) begin
                n_err++; $display("FAIL conflict_addr[%0d] got %h exp %h", i, ack_log[i], 32'h100 + 32'(4 * i)); end
        end
        n_cmp++; if (data_o !== mem_word(32'h100)) begin
            n_err++; $display("FAIL conflict_data got %h exp %h", data_o, mem_word(32'h100)); end
        run_fill(32'h0, fs, to);
        n_cmp++; if (to || !fs) begin
            n_err++; $display("FAIL conflict_miss2 got stall0=%b timeout=%b exp 1/0", fs, to); end
        n_cmp++; if (ack_log.size() == 0 || ack_log[0] !== 32'h0) begin
            n_err++; $display("FAIL conflict_refill2 got %0d words exp first addr 0", ack_log.size()); end
        n_cmp++; if (data_o !== 32'h1111_1111) begin
            n_err++; $display("FAIL conflict_data2 got %h exp 11111111", data_o); end
    endtask

    task automatic test_flush_in_refill();
        int acks = 0;
        bit flushed = 1'b0;
        bit fl, fs, to;
        for (int i = 0; i < 30 && acks < 4; i++) begin
            fl = (acks == 1) && !flushed;
            cycle(1'b1, 32'h200, fl);
            if (fl) flushed = 1'b1;
            if (mem_req_o && mem_ack_i) acks++;
        end
        n_cmp++; if (acks != 4 || !flushed) begin
            n_err++; $display("FAIL flush_burst_words got %0d exp 4", acks); end
        cycle(1'b1, 32'h200, 1'b0);
        n_cmp++; if (mem_req_o !== 1'b0 || stallreq_o !== 1'b1) begin
            n_err++; $display("FAIL flush_commit got req=%b stall=%b exp 0/1", mem_req_o, stallreq_o); end
        cycle(1'b1, 32'h200, 1'b0);
        n_cmp++; if (stallreq_o !== 1'b1 || data_o !== 32'd0) begin
            n_err++; $display("FAIL flush_remiss got stall=%b data=%h exp 1/0", stallreq_o, data_o); end
        cycle(1'b1, 32'h200, 1'b0);
        n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin
            n_err++; $display("FAIL flush_new_refill got req=%b addr=%h exp 1/200", mem_req_o, mem_addr_o); end
        run_fill(32'h200, fs, to);
        n_cmp++; if (to || data_o !== mem_word(32'h200)) begin
            n_err++; $display("FAIL flush_refill_data got %h exp %h", data_o, mem_word(32'h200)); end
    endtask

    task automatic test_disable();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, $urandom, 1'b0);
            n_cmp++; if (data_o !== 32'd0 || stallreq_o !== 1'b0 || mem_req_o !== 1'b0) begin
                n_err++; $display("FAIL disable[%0d] got data=%h stall=%b req=%b exp 0/0/0", i, data_o, stallreq_o, mem_req_o); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        rand_ack = 1'b1;
        for (int i = 0; i < 400; i++) begin
            a = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
            cycle($urandom_range(0, 6) != 0, a, $urandom_range(0, 40) == 0);
            n_cmp++; if (stallreq_o !== exp_stall) begin
                n_err++; $display("FAIL rand_stall[%0d] got %b exp %b", i, stallreq_o, exp_stall); end
            n_cmp++; if (data_o !== exp_data) begin
                n_err++; $display("FAIL rand_data[%0d] got %h exp %h", i, data_o, exp_data); end
            n_cmp++; if (mem_req_o !== exp_req) begin
                n_err++; $display("FAIL rand_req[%0d] got %b exp %b", i, mem_req_o, exp_req); end
            if (exp_req) begin
                n_cmp++; if (mem_addr_o !== exp_addr) begin
                    n_err++; $display("FAIL rand_addr[%0d] got %h exp %h", i, mem_addr_o, exp_addr); end
            end
        end
        rand_ack = 1'b0;
        for (int i = 0; i < 40 && m_phase != 0; i++) cycle(1'b0, 32'd0, 1'b0);
        cycle(1'b0, 32'd0, 1'b0);
        n_cmp++; if (m_phase != 0 || mem_req_o !== 1'b0) begin
            n_err++; $display("FAIL rand_drain got req=%b exp 0", mem_req_o); end
    endtask

    task automatic test_reset_mid_refill();
        int acks = 0;
        for (int i = 0; i < 30 && acks < 2; i++) begin
            cycle(1'b1, 32'h300, 1'b0);
            if (mem_req_o && mem_ack_i) acks++;
        end
        @(posedge clk);
        #3;
        rst  = 1'b0;
        ce_i = 1'b0;
        #1;
        n_cmp++; if (mem_req_o !== 1'b0 || mem_addr_o !== 32'd0 || dbg_state !== 2'd0) begin
            n_err++; $display("FAIL rstmid_outputs got req=%b addr=%h state=%0d exp 0/0/0", mem_req_o, mem_addr_o, dbg_state); end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 32'h0, 1'b0);
        n_cmp++; if (stallreq_o !== 1'b1) begin
            n_err++; $display("FAIL rstmid_remiss got %b exp 1", stallreq_o); end
        cycle(1'b1, 32'h0, 1'b0);
        n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            n_err++; $display("FAIL rstmid_restart got req=%b addr=%h exp 1/0", mem_req_o, mem_addr_o); end
`ifdef ICACHE_STATS_EN
        n_cmp++; if (miss_cnt_o !== 32'd1) begin
            n_err++; $display("FAIL rstmid_miss_cnt got %0d exp 1", miss_cnt_o); end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_sequential_hits();
        test_conflict();
        test_flush_in_refill();
        test_disable();
        test_random();
        test_reset_mid_refill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
